xs3_code_converter: RTL

//  Parametrised multi-digit BCD <-> Excess-3 code converter with valid/ready handshakes on both sides.

---
 rtl/xs3_pkg.sv | 14 +
 rtl/xs3_digit.sv | 28 ++
 rtl/xs3_code_converter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/xs3_pkg.sv
// Shared types and constants for the BCD <-> Excess-3 converter.
// Latency: n/a (definitions only). Backpressure: n/a.
package xs3_pkg;

    typedef enum logic [1:0] {IDLE, CONV, DONE} xs3_state_t;

    localparam int         DIGIT_W    = 4;
    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] XS3_MIN    = 4'd3;
    localparam logic [3:0] XS3_MAX    = 4'd12;
    localparam logic [3:0] ERR_NIBBLE = 4'hF;

endpackage

// File: rtl/xs3_digit.sv
// Single-digit BCD <-> Excess-3 mapping with illegal-digit flag.
// Latency: combinational. Backpressure: none.
module xs3_digit
    import xs3_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       mode,
    output logic [3:0] res,
    output logic       err
);

    always_comb begin
        res = ERR_NIBBLE;
        err = 1'b1;
        if (!mode) begin
            if (digit <= BCD_MAX) begin
                res = digit + XS3_OFFSET;
                err = 1'b0;
            end
        end else begin
            if ((digit >= XS3_MIN) && (digit <= XS3_MAX)) begin
                res = digit - XS3_OFFSET;
                err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/xs3_code_converter.sv
// Multi-digit BCD <-> Excess-3 converter, one digit per cycle, LSD first.
// Latency: out_valid DIGITS+1 cycles after accept. Backpressure: holds result in DONE until out_ready.
module xs3_code_converter
    import xs3_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int DW     = DIGITS * DIGIT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [DIGITS-1:0] out_err,
    output logic              busy
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    xs3_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     src_q, src_d;
    logic [DW-1:0]     res_q, res_d;
    logic [DIGITS-1:0] err_q, err_d;
    logic              mode_q, mode_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic [3:0]        digit_sel;
    logic [3:0]        digit_res;
    logic              digit_err;

    assign digit_sel = src_q[DIGIT_W*int'(cnt_q) +: DIGIT_W];

    xs3_digit u_digit (
        .digit (digit_sel),
        .mode  (mode_q),
        .res   (digit_res),
        .err   (digit_err)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        src_d       = src_q;
        res_d       = res_q;
        err_d       = err_q;
        mode_d      = mode_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    src_d      = in_data;
                    mode_d     = mode;
                    res_d      = '0;
                    err_d      = '0;
                    cnt_d      = '0;
                    state_d    = CONV;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            CONV: begin
                res_d[DIGIT_W*int'(cnt_q) +: DIGIT_W] = digit_res;
                err_d[cnt_q]                          = digit_err;
                if (cnt_q == CW'(DIGITS - 1)) begin
                    cnt_d       = '0;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                // Result stays frozen here for as long as downstream stalls.
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            src_q       <= '0;
            res_q       <= '0;
            err_q       <= '0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            res_q       <= res_d;
            err_q       <= err_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = res_q;
    assign out_err   = err_q;
    assign busy      = busy_q;

endmodule
